pulse_strobe_gen: RTL and testbench

//  Turns a one-cycle trigger into a timed level strobe: setup gap, N-cycle active strobe, hold gap.
//  It is the inverse of the posedge detector, which turns a level into a pulse.

---
 rtl/pulse_strobe_gen_if.sv | 28 ++
 rtl/pulse_strobe_gen.sv | 107 ++++++++++
 tb/tb_pulse_strobe_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_strobe_gen_if.sv
// pulse_strobe_gen_if: request/status bundle between a sequencer and pulse_strobe_gen.
//   trig_in    : one-cycle start request
//   len_in     : strobe width for the request (0 selects the default width)
//   strobe_out : generated strobe
//   busy_out   : generator is running a request
//   done_out   : one-cycle pulse when the generator returns to idle
//   drop_out   : one-cycle pulse when a request was rejected
// master = sequencer side, slave = generator side.
interface pulse_strobe_gen_if #(
   parameter int CNT_W = 8
);
   logic             trig_in;
   logic [CNT_W-1:0] len_in;
   logic             strobe_out;
   logic             busy_out;
   logic             done_out;
   logic             drop_out;

   modport master (
      output trig_in, len_in,
      input  strobe_out, busy_out, done_out, drop_out
   );

   modport slave (
      input  trig_in, len_in,
      output strobe_out, busy_out, done_out, drop_out
   );
endinterface

// File: rtl/pulse_strobe_gen.sv
// pulse_strobe_gen: converts a one-cycle trigger into a timed level strobe
// (setup gap, L-cycle strobe, hold gap) with busy/done/drop handshake flags.
// Ports:
//   clk_in : system clock, rising edge
//   rst_in : asynchronous reset, active-high
//   bus    : pulse_strobe_gen_if.slave (trig_in, len_in in; strobe/busy/done/drop out)
// All outputs are registers; nothing combinational reaches the interface outputs.
module pulse_strobe_gen #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 1,
   parameter int CNT_W     = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   pulse_strobe_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] SETUP_N = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_N = CNT_W'(PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;     // cycles remaining in the current state, counts down to 1
   logic [CNT_W-1:0] len_q;   // strobe width latched at accept
   logic [CNT_W-1:0] len_sel;

   always_comb begin
      len_sel = (bus.len_in == '0) ? PULSE_N : bus.len_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= IDLE;
         cnt            <= '0;
         len_q          <= '0;
         bus.strobe_out <= 1'b0;
         bus.busy_out   <= 1'b0;
         bus.done_out   <= 1'b0;
         bus.drop_out   <= 1'b0;
      end else begin
         bus.done_out <= 1'b0;
         // busy_out is low only in IDLE, so this also covers the done edge
         bus.drop_out <= bus.trig_in & bus.busy_out;
         case (state)
            IDLE: begin
               if (bus.trig_in) begin
                  len_q        <= len_sel;
                  bus.busy_out <= 1'b1;
                  if (SETUP_CYC > 0) begin
                     state <= SETUP;
                     cnt   <= SETUP_N;
                  end else begin
                     state          <= ACTIVE;
                     cnt            <= len_sel;
                     bus.strobe_out <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (cnt == ONE) begin
                  state          <= ACTIVE;
                  cnt            <= len_q;
                  bus.strobe_out <= 1'b1;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            ACTIVE: begin
               // counting down to 1 (not 0) lets L = 2**CNT_W-1 fit without wrap
               if (cnt == ONE) begin
                  bus.strobe_out <= 1'b0;
                  if (HOLD_CYC > 0) begin
                     state <= HOLD;
                     cnt   <= HOLD_N;
                  end else begin
                     state        <= IDLE;
                     cnt          <= '0;
                     bus.busy_out <= 1'b0;
                     bus.done_out <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            HOLD: begin
               if (cnt == ONE) begin
                  state        <= IDLE;
                  cnt          <= '0;
                  bus.busy_out <= 1'b0;
                  bus.done_out <= 1'b1;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_strobe_gen.sv
// tb_pulse_strobe_gen: checks two generator instances (default timing, and
// zero setup/hold) with a fixed vector table, hand sequences for long widths,
// held trigger and async reset, and a randomized run against a timing model.
module tb_pulse_strobe_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pulse_strobe_gen_if #(.CNT_W(8)) if_a ();
   pulse_strobe_gen_if #(.CNT_W(8)) if_b ();

   pulse_strobe_gen #(.SETUP_CYC(1), .PULSE_CYC(4), .HOLD_CYC(1), .CNT_W(8)) dut_a (
      .clk_in(clk), .rst_in(rst), .bus(if_a));
   pulse_strobe_gen #(.SETUP_CYC(0), .PULSE_CYC(4), .HOLD_CYC(0), .CNT_W(8)) dut_b (
      .clk_in(clk), .rst_in(rst), .bus(if_b));

   int n_vec = 0;
   int n_bad = 0;

   // ---- timing model: outputs follow from accept edge, width and S/H gaps ----
   int m_s[2] = '{1, 0};
   int m_h[2] = '{1, 0};
   bit has_acc[2];
   int acc_e[2];
   int acc_l[2];
   bit exp_drop[2];
   int e_now = 0;

   function automatic int total(int d);
      return m_s[d] + acc_l[d] + m_h[d];
   endfunction

   function automatic bit m_busy(int d, int e);
      int off;
      if (!has_acc[d]) return 1'b0;
      off = e - acc_e[d];
      return (off >= 0) && (off < total(d));
   endfunction

   function automatic bit m_strobe(int d, int e);
      int off;
      if (!has_acc[d]) return 1'b0;
      off = e - acc_e[d];
      return (off >= m_s[d]) && (off < m_s[d] + acc_l[d]);
   endfunction

   function automatic bit m_done(int d, int e);
      if (!has_acc[d]) return 1'b0;
      return (e - acc_e[d]) == total(d);
   endfunction

   task automatic chk(string name, logic act, logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(int d, bit tr, logic [7:0] ln);
      bit bp;
      bp = m_busy(d, e_now - 1);
      exp_drop[d] = tr && bp;
      if (tr && !bp) begin
         has_acc[d] = 1'b1;
         acc_e[d]   = e_now;
         acc_l[d]   = (ln == 8'd0) ? 4 : int'(ln);
      end
   endtask

   // one clock edge: drive both DUTs, advance model, sample 1 ns after the edge
   task automatic step(bit ta, logic [7:0] la, bit tb, logic [7:0] lb);
      if_a.trig_in = ta; if_a.len_in = la;
      if_b.trig_in = tb; if_b.len_in = lb;
      @(posedge clk);
      e_now++;
      model_edge(0, ta, la);
      model_edge(1, tb, lb);
      #1;
      chk("a_strobe", if_a.strobe_out, m_strobe(0, e_now));
      chk("a_busy",   if_a.busy_out,   m_busy(0, e_now));
      chk("a_done",   if_a.done_out,   m_done(0, e_now));
      chk("a_drop",   if_a.drop_out,   exp_drop[0]);
      chk("b_strobe", if_b.strobe_out, m_strobe(1, e_now));
      chk("b_busy",   if_b.busy_out,   m_busy(1, e_now));
      chk("b_done",   if_b.done_out,   m_done(1, e_now));
      chk("b_drop",   if_b.drop_out,   exp_drop[1]);
   endtask

   // accept one request of width len on dut_a and measure strobe/busy lengths
   task automatic run_len(logic [7:0] len, int exp_s, int exp_b);
      int ns, nb;
      bit seen;
      ns = 0; nb = 0; seen = 1'b0;
      step(1'b1, len, 1'b0, 8'd0);
      ns += int'(if_a.strobe_out); nb += int'(if_a.busy_out);
      for (int i = 0; i < 400 && !seen; i++) begin
         step(1'b0, 8'd0, 1'b0, 8'd0);
         ns += int'(if_a.strobe_out); nb += int'(if_a.busy_out);
         seen = if_a.done_out;
      end
      chk("len_done_seen", seen, 1'b1);
      chk_int("len_strobe_cycles", ns, exp_s);
      chk_int("len_busy_cycles", nb, exp_b);
      step(1'b0, 8'd0, 1'b0, 8'd0);
   endtask

   typedef struct {
      bit         sel;
      bit         trig;
      logic [7:0] len;
      bit         s, b, d, r;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit sel, bit trig, logic [7:0] len, bit s, bit b, bit d, bit r);
      vec_t v;
      v.sel = sel; v.trig = trig; v.len = len; v.s = s; v.b = b; v.d = d; v.r = r;
      return v;
   endfunction

   initial begin
      int drops;
      // T1: default timing, len 0
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      // T3: no setup/hold, len 2
      tbl.push_back(mk(1, 1, 2, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      // T4: drop mid-run and on the done edge, accept right after
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));

      if_a.trig_in = 1'b0; if_a.len_in = 8'd0;
      if_b.trig_in = 1'b0; if_b.len_in = 8'd0;

      // reset state
      #2;
      chk("rst_a_strobe", if_a.strobe_out, 1'b0);
      chk("rst_a_busy",   if_a.busy_out,   1'b0);
      chk("rst_a_done",   if_a.done_out,   1'b0);
      chk("rst_a_drop",   if_a.drop_out,   1'b0);
      chk("rst_b_busy",   if_b.busy_out,   1'b0);
      chk("rst_b_strobe", if_b.strobe_out, 1'b0);
      #10 rst = 1'b0;

      // table vectors
      foreach (tbl[i]) begin
         if (tbl[i].sel) step(1'b0, 8'd0, tbl[i].trig, tbl[i].len);
         else            step(tbl[i].trig, tbl[i].len, 1'b0, 8'd0);
         chk("tbl_strobe", tbl[i].sel ? if_b.strobe_out : if_a.strobe_out, tbl[i].s);
         chk("tbl_busy",   tbl[i].sel ? if_b.busy_out   : if_a.busy_out,   tbl[i].b);
         chk("tbl_done",   tbl[i].sel ? if_b.done_out   : if_a.done_out,   tbl[i].d);
         chk("tbl_drop",   tbl[i].sel ? if_b.drop_out   : if_a.drop_out,   tbl[i].r);
      end

      // T2: width boundaries
      run_len(8'd1,   1,   3);
      run_len(8'd255, 255, 257);

      // T5: trigger held high for 20 edges
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'd0, 1'b0, 8'd0);
         drops += int'(if_a.drop_out);
      end
      chk_int("held_trig_drops", drops, 17);
      for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b0, 8'd0);

      // T6: async reset mid-ACTIVE, between edges
      step(1'b1, 8'd0, 1'b1, 8'd0);
      step(1'b0, 8'd0, 1'b0, 8'd0);
      step(1'b0, 8'd0, 1'b0, 8'd0);
      chk("pre_rst_strobe", if_a.strobe_out, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_strobe", if_a.strobe_out, 1'b0);
      chk("async_rst_busy",   if_a.busy_out,   1'b0);
      chk("async_rst_done",   if_a.done_out,   1'b0);
      chk("async_rst_b_busy", if_b.busy_out,   1'b0);
      has_acc[0] = 1'b0; has_acc[1] = 1'b0;
      #2 rst = 1'b0;
      step(1'b1, 8'd0, 1'b0, 8'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b0, 8'd0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit ta, tb;
         logic [7:0] la, lb;
         int r;
         ta = ($urandom_range(0, 3) == 0);
         tb = ($urandom_range(0, 2) == 0);
         r  = $urandom_range(0, 19);
         la = (r < 4) ? 8'd0 : (r == 19) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 6));
         r  = $urandom_range(0, 9);
         lb = (r < 2) ? 8'd0 : 8'($urandom_range(1, 5));
         step(ta, la, tb, lb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
